// File: rtl/text_line_fetcher_pkg.sv
// Shared constants for the text-mode video memory: read/write select codes,
// address widths and the line fetcher state encoding.
package text_line_fetcher_pkg;

   // Select field values in bits [15:13] of a video memory address
   localparam logic [2:0] CMD_CHAR = 3'b000;
   localparam logic [2:0] CMD_FONT = 3'b001;

   // Offset widths of the character buffer and the font memory
   localparam int CHAR_AW = 13;
   localparam int FONT_AW = 12;

   // Line fetcher sequencing states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_C_ADDR = 3'd1,
      ST_C_WAIT = 3'd2,
      ST_F_ADDR = 3'd3,
      ST_F_WAIT = 3'd4,
      ST_OUT    = 3'd5
   } fetch_state_t;

endpackage

// File: rtl/text_line_fetcher.sv
// Text-mode scan line fetcher: for every column of a scan line it reads the
// character code, then the matching glyph row, and hands one pixel byte per
// cell to the serializer over a valid/ready handshake.
module text_line_fetcher
   import text_line_fetcher_pkg::*;
#(
   parameter int COLS       = 80,
   parameter int ROWS       = 30,
   parameter int FONT_H     = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        line_start,
   input  logic [8:0]  line_num,
   output logic        busy,
   output logic        line_err,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic [7:0]  pix_data,
   output logic        pix_valid,
   output logic        pix_last,
   input  logic        pix_ready
);

   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int LAT_W = $clog2(RD_LATENCY + 1);
   localparam int LINES = ROWS * FONT_H;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
   localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(RD_LATENCY - 1);

   // Parameter legality: the whole char grid must fit the char address space
   if (ROWS * COLS > 8192) begin : g_bad_cells
      $error("text_line_fetcher: ROWS*COLS exceeds the character address space");
   end
   if (RD_LATENCY < 1) begin : g_bad_latency
      $error("text_line_fetcher: RD_LATENCY must be at least 1");
   end

   fetch_state_t         state_q, state_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic [LAT_W-1:0]     lat_q, lat_d;
   logic [CHAR_AW-1:0]   cell_base_q, cell_base_d;
   logic [3:0]           glyph_q, glyph_d;
   logic [15:0]          rd_addr_q, rd_addr_d;
   logic [7:0]           pix_data_q, pix_data_d;
   logic                 pix_valid_q, pix_valid_d;
   logic                 pix_last_q, pix_last_d;
   logic                 busy_q, busy_d;
   logic                 line_err_q, line_err_d;

   logic                 line_ok_s;
   logic [CHAR_AW-1:0]   base_s;
   logic [3:0]           glyph_s;
   logic [FONT_AW-1:0]   font_off_s;
   logic [CHAR_AW-1:0]   char_next_s;

   // Decode the requested line into its first cell address and glyph row
   always_comb begin
      line_ok_s   = ({1'b0, line_num} < 10'(LINES));
      base_s      = CHAR_AW'(line_num / 9'(FONT_H)) * CHAR_AW'(COLS);
      glyph_s     = 4'(line_num % 9'(FONT_H));
      font_off_s  = {rd_data, glyph_q};
      char_next_s = cell_base_q + CHAR_AW'(col_q) + CHAR_AW'(1);
   end

   // Next-state and output sequencing; the address is loaded on entry to
   // each *_ADDR state so the memory sees it for the whole wait window
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      lat_d       = lat_q;
      cell_base_d = cell_base_q;
      glyph_d     = glyph_q;
      rd_addr_d   = rd_addr_q;
      pix_data_d  = pix_data_q;
      pix_valid_d = pix_valid_q;
      pix_last_d  = pix_last_q;
      busy_d      = busy_q;
      line_err_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (line_start) begin
               if (line_ok_s) begin
                  state_d     = ST_C_ADDR;
                  cell_base_d = base_s;
                  glyph_d     = glyph_s;
                  col_d       = '0;
                  busy_d      = 1'b1;
                  rd_addr_d   = {CMD_CHAR, base_s};
               end else begin
                  line_err_d  = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_C_ADDR: begin
            state_d = ST_C_WAIT;
            lat_d   = '0;
         end
         ST_C_WAIT: begin
            // char code arrives now: turn it straight into the font address
            if (lat_q == LAST_LAT) begin
               state_d   = ST_F_ADDR;
               rd_addr_d = {CMD_FONT, CHAR_AW'(font_off_s)};
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         ST_F_ADDR: begin
            state_d = ST_F_WAIT;
            lat_d   = '0;
         end
         ST_F_WAIT: begin
            if (lat_q == LAST_LAT) begin
               state_d     = ST_OUT;
               pix_data_d  = rd_data;
               pix_valid_d = 1'b1;
               pix_last_d  = (col_q == LAST_COL);
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         ST_OUT: begin
            if (pix_ready) begin
               pix_valid_d = 1'b0;
               pix_last_d  = 1'b0;
               if (col_q == LAST_COL) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d   = ST_C_ADDR;
                  col_d     = col_q + COL_W'(1);
                  rd_addr_d = {CMD_CHAR, char_next_s};
               end
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any line in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         lat_q       <= '0;
         cell_base_q <= '0;
         glyph_q     <= 4'h0;
         rd_addr_q   <= 16'h0000;
         pix_data_q  <= 8'h00;
         pix_valid_q <= 1'b0;
         pix_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         line_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         lat_q       <= lat_d;
         cell_base_q <= cell_base_d;
         glyph_q     <= glyph_d;
         rd_addr_q   <= rd_addr_d;
         pix_data_q  <= pix_data_d;
         pix_valid_q <= pix_valid_d;
         pix_last_q  <= pix_last_d;
         busy_q      <= busy_d;
         line_err_q  <= line_err_d;
      end
   end

   assign busy      = busy_q;
   assign line_err  = line_err_q;
   assign rd_addr   = rd_addr_q;
   assign pix_data  = pix_data_q;
   assign pix_valid = pix_valid_q;
   assign pix_last  = pix_last_q;

endmodule

// File: tb/tb_text_line_fetcher.sv
// Directed bench for text_line_fetcher: char buffer and font memory are
// modelled as 1-cycle synchronous ROMs behind the 16-bit address decode.
module tb_text_line_fetcher;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        line_start = 1'b0;
   logic [8:0]  line_num = 9'd0;
   logic        busy;
   logic        line_err;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data = 8'h00;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        pix_last;
   logic        pix_ready = 1'b1;

   logic [7:0]  char_mem [0:8191];
   logic [7:0]  font_mem [0:4095];

   int total = 0;
   int bad   = 0;

   text_line_fetcher #(
      .COLS(80), .ROWS(30), .FONT_H(16), .RD_LATENCY(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_num(line_num),
      .busy(busy), .line_err(line_err), .rd_addr(rd_addr), .rd_data(rd_data),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last),
      .pix_ready(pix_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_read(input logic [15:0] a);
      case (a[15:13])
         3'b000:  mem_read = char_mem[a[12:0]];
         3'b001:  mem_read = font_mem[a[11:0]];
         default: mem_read = 8'h00;
      endcase
   endfunction

   // Registered-read memory model
   always @(posedge clk) rd_data <= mem_read(rd_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_pix(input int line, input int col);
      logic [7:0]  code;
      logic [11:0] fa;
      code = char_mem[(line / 16) * 80 + col];
      fa   = {code, 4'(line % 16)};
      return font_mem[fa];
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_err"},   line_err, 0);
      check({tag, "_addr"},  rd_addr, 0);
      check({tag, "_data"},  pix_data, 0);
      check({tag, "_valid"}, pix_valid, 0);
      check({tag, "_last"},  pix_last, 0);
   endtask

   // Fetch one line; optional stall (10 cycles), busy-time line_start pulse,
   // or reset abort at the given column (-1 disables each)
   task automatic fetch_line(input int line, input int stall_col, input int pulse_col,
                             input int abort_col, output logic [7:0] first_b,
                             output logic [7:0] last_b, output logic [15:0] max_char);
      int count, cyc, first_cyc, last_cyc;
      bit pulsed, err_seen;
      logic [7:0]  hold_data;
      logic [15:0] hold_addr;
      count = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
      pulsed = 0; err_seen = 0; max_char = 16'h0000;
      first_b = 8'h00; last_b = 8'h00;
      pix_ready = 1'b1;
      @(negedge clk);
      line_start = 1'b1;
      line_num   = 9'(line);
      @(negedge clk);
      line_start = 1'b0;
      cyc = 1;
      check("busy_set", busy, 1);
      while (count < 80 && cyc < 1000) begin
         line_start = 1'b0;
         if (line_err) err_seen = 1;
         if (rd_addr[15:13] == 3'b000 && rd_addr > max_char) max_char = rd_addr;
         if (pix_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (count == abort_col) begin
               rst_n = 1'b0;
               #1;
               check_all_zero("abort");
               break;
            end
            if (count == stall_col) begin
               pix_ready = 1'b0;
               hold_data = pix_data;
               hold_addr = rd_addr;
               for (int i = 0; i < 10; i++) begin
                  @(negedge clk);
                  cyc++;
                  check("stall_valid", pix_valid, 1);
                  check("stall_data", pix_data, hold_data);
                  check("stall_addr", rd_addr, hold_addr);
               end
            end
            pix_ready = 1'b1;
            check("pix_data", pix_data, exp_pix(line, count));
            check("pix_last", pix_last, (count == 79) ? 1 : 0);
            if (count == 0) first_b = pix_data;
            if (count == 79) begin
               last_b   = pix_data;
               last_cyc = cyc;
            end
            if (count == pulse_col && !pulsed) begin
               line_start = 1'b1;
               line_num   = 9'd200;
               pulsed     = 1;
            end
            count++;
         end
         @(negedge clk);
         cyc++;
      end
      line_start = 1'b0;
      if (abort_col < 0) begin
         check("byte_count", count, 80);
         check("first_latency", first_cyc, 5);
         check("line_cycles", last_cyc, (stall_col >= 0) ? 410 : 400);
         check("end_busy", busy, 0);
         check("end_valid", pix_valid, 0);
         check("no_line_err", err_seen, 0);
      end
   endtask

   initial begin
      logic [7:0]  fb, lb;
      logic [15:0] mc, hold;

      for (int i = 0; i < 8192; i++) char_mem[i] = 8'(i * 7 + 3);
      for (int a = 0; a < 4096; a++) font_mem[a] = 8'((a * 13) ^ (a >> 4));
      char_mem[0]        = 8'h41;
      char_mem[2399]     = 8'hFF;
      font_mem[12'h413]  = 8'h18;
      font_mem[12'hFFF]  = 8'hA5;

      // reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // 1: line 3, first cell 'A' glyph row 3
      fetch_line(3, -1, -1, -1, fb, lb, mc);
      check("t1_first_byte", fb, 8'h18);
      check("t1_max_char_addr", mc, 16'h004F);

      // 2: last line of the frame, last cell must not wrap
      fetch_line(479, -1, -1, -1, fb, lb, mc);
      check("t2_last_byte", lb, 8'hA5);
      check("t2_max_char_addr", mc, 16'h095F);

      // 3: out-of-range line
      @(negedge clk);
      hold       = rd_addr;
      line_start = 1'b1;
      line_num   = 9'd480;
      @(negedge clk);
      line_start = 1'b0;
      check("t3_err_pulse", line_err, 1);
      check("t3_busy", busy, 0);
      check("t3_addr", rd_addr, hold);
      @(negedge clk);
      check("t3_err_drop", line_err, 0);
      check("t3_busy2", busy, 0);
      check("t3_addr2", rd_addr, hold);

      // 4: consumer stall on column 5
      fetch_line(37, 5, -1, -1, fb, lb, mc);

      // 5: line_start while busy is ignored
      fetch_line(64, -1, 10, -1, fb, lb, mc);

      // 6: reset at column 40, then a fresh full line
      fetch_line(10, -1, -1, 40, fb, lb, mc);
      repeat (2) @(negedge clk);
      check_all_zero("rst_hold");
      rst_n = 1'b1;
      @(negedge clk);
      fetch_line(10, -1, -1, -1, fb, lb, mc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
